// File: rtl/mux8way_arbiter_if.sv
// Bundle for the eight producer channels and the single merged consumer stream.
// The arbiter takes the slave view; the producer/consumer side takes the master view.
interface mux8way_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [WIDTH-1:0] inC;
    logic [WIDTH-1:0] inD;
    logic [WIDTH-1:0] inE;
    logic [WIDTH-1:0] inF;
    logic [WIDTH-1:0] inG;
    logic [WIDTH-1:0] inH;
    logic [7:0]       inValid;
    logic [7:0]       inReady;
    logic [WIDTH-1:0] out;
    logic             outValid;
    logic             outReady;
    logic [2:0]       select;

    modport slave (
        input  inA, inB, inC, inD, inE, inF, inG, inH,
        input  inValid, outReady,
        output inReady, out, outValid, select
    );

    modport master (
        output inA, inB, inC, inD, inE, inF, inG, inH,
        output inValid, outReady,
        input  inReady, out, outValid, select
    );
endinterface

// File: rtl/mux8way_arbiter.sv
// Round-robin 8:1 merge of valid/ready channels into one registered output word.
// The output word is tagged with its source index (0=A .. 7=H) so responses can be routed back.
module mux8way_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mux8way_arbiter_if.slave    bus
);
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           stateR;
    logic [2:0]       ptrR;
    logic [WIDTH-1:0] outR;
    logic [2:0]       selectR;
    logic             outValidR;

    logic [WIDTH-1:0] inData [8];
    logic             loadS;
    logic             grantFoundS;
    logic [2:0]       grantIdxS;
    logic [2:0]       scanIdxS;
    logic [7:0]       inReadyS;

    assign inData[0] = bus.inA;
    assign inData[1] = bus.inB;
    assign inData[2] = bus.inC;
    assign inData[3] = bus.inD;
    assign inData[4] = bus.inE;
    assign inData[5] = bus.inF;
    assign inData[6] = bus.inG;
    assign inData[7] = bus.inH;

    // The output register can take a new word when empty or when its word leaves this cycle.
    assign loadS = (stateR == EMPTY) || bus.outReady;

    // Find the first valid channel scanning upward from the round-robin pointer, wrapping H to A.
    always_comb begin
        grantFoundS = 1'b0;
        grantIdxS   = 3'd0;
        scanIdxS    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            scanIdxS = ptrR + 3'(k);
            if (!grantFoundS && bus.inValid[scanIdxS]) begin
                grantFoundS = 1'b1;
                grantIdxS   = scanIdxS;
            end else begin
                grantFoundS = grantFoundS;
            end
        end
    end

    // Accept strobe: one-hot on the granted channel, held low while in reset so nothing is lost.
    always_comb begin
        inReadyS = 8'd0;
        if (rst_n && loadS && grantFoundS) begin
            inReadyS = 8'd1 << grantIdxS;
        end else begin
            inReadyS = 8'd0;
        end
    end

    assign bus.inReady  = inReadyS;
    assign bus.out      = outR;
    assign bus.select   = selectR;
    assign bus.outValid = outValidR;

    // Output register FSM: capture the granted word, drain on outReady, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR    <= EMPTY;
            ptrR      <= 3'd0;
            outR      <= {WIDTH{1'b0}};
            selectR   <= 3'd0;
            outValidR <= 1'b0;
        end else begin
            case (stateR)
                EMPTY: begin
                    if (grantFoundS) begin
                        stateR    <= FULL;
                        outR      <= inData[grantIdxS];
                        selectR   <= grantIdxS;
                        outValidR <= 1'b1;
                        ptrR      <= grantIdxS + 3'd1;
                    end else begin
                        stateR    <= EMPTY;
                        outValidR <= 1'b0;
                    end
                end
                FULL: begin
                    if (bus.outReady && grantFoundS) begin
                        stateR    <= FULL;
                        outR      <= inData[grantIdxS];
                        selectR   <= grantIdxS;
                        outValidR <= 1'b1;
                        ptrR      <= grantIdxS + 3'd1;
                    end else if (bus.outReady) begin
                        stateR    <= EMPTY;
                        outValidR <= 1'b0;
                    end else begin
                        stateR    <= FULL;
                        outValidR <= 1'b1;
                    end
                end
                default: begin
                    stateR    <= EMPTY;
                    outValidR <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux8way_arbiter.sv
// Self-checking bench for mux8way_arbiter: directed scenarios plus a randomized run
// compared against a word-level round-robin reference model.
module tb_mux8way_arbiter;
    logic clk;
    logic rst_n;

    mux8way_arbiter_if #(.WIDTH(16)) bus ();

    mux8way_arbiter #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source side state driven by the bench.
    logic [15:0] srcData [8];
    logic [7:0]  srcValid;
    logic        rdy;

    // Reference model: is a word held, which word/tag, and where the round-robin search starts.
    bit          mFull;
    logic [15:0] mOut;
    logic [2:0]  mSel;
    int          mPtr;

    // Per-cycle observations.
    logic [7:0]  obsInReady;
    logic [7:0]  expInReady;
    int          expGrant;
    int          accepted;
    int          emitted;

    function automatic int refGrant(logic [7:0] v, int p, bit canLoad);
        if (!canLoad) return -1;
        for (int k = 0; k < 8; k++) begin
            if (v[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, sample inReady, clock, advance the model and the sources.
    task automatic tick();
        bit outHs;
        bus.inA = srcData[0]; bus.inB = srcData[1]; bus.inC = srcData[2]; bus.inD = srcData[3];
        bus.inE = srcData[4]; bus.inF = srcData[5]; bus.inG = srcData[6]; bus.inH = srcData[7];
        bus.inValid  = srcValid;
        bus.outReady = rdy;
        #1;
        obsInReady = bus.inReady;
        expGrant   = refGrant(srcValid, mPtr, (!mFull) || rdy);
        expInReady = (expGrant >= 0) ? (8'd1 << expGrant) : 8'd0;
        outHs      = bus.outValid && rdy;
        @(posedge clk);
        #1;
        if (outHs) emitted++;
        if (expGrant >= 0) begin
            mOut  = srcData[expGrant];
            mSel  = 3'(expGrant);
            mFull = 1'b1;
            mPtr  = (expGrant + 1) % 8;
        end else if (!mFull || rdy) begin
            mFull = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (obsInReady[i]) begin
                accepted++;
                srcValid[i] = 1'b0;
            end
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        srcValid = 8'd0;
        rdy = 1'b0;
        bus.inValid = 8'd0;
        bus.outReady = 1'b0;
        mFull = 1'b0; mOut = 16'd0; mSel = 3'd0; mPtr = 0;
        accepted = 0; emitted = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) srcData[i] = 16'h5000 + 16'(i);
        resetDut();
        srcValid = 8'h01; rdy = 1'b0;
        tick();
        srcValid = 8'hFF; rdy = 1'b0;
        tick();
        checks++;
        if (bus.outValid !== 1'b1) begin
            errors++; $display("FAIL reset_prefull outValid got %b exp 1", bus.outValid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.outValid !== 1'b0) begin
            errors++; $display("FAIL reset_outValid got %b exp 0", bus.outValid);
        end
        checks++;
        if (bus.out !== 16'd0) begin
            errors++; $display("FAIL reset_out got %h exp 0000", bus.out);
        end
        checks++;
        if (bus.select !== 3'd0) begin
            errors++; $display("FAIL reset_select got %0d exp 0", bus.select);
        end
        checks++;
        if (bus.inReady !== 8'd0) begin
            errors++; $display("FAIL reset_inReady got %h exp 00", bus.inReady);
        end
        mFull = 1'b0; mOut = 16'd0; mSel = 3'd0; mPtr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        srcValid = 8'hFF; rdy = 1'b1;
        tick();
        checks++;
        if (obsInReady !== 8'h01) begin
            errors++; $display("FAIL reset_firstGrant inReady got %h exp 01", obsInReady);
        end
        checks++;
        if (bus.select !== 3'd0 || bus.out !== 16'h5000) begin
            errors++; $display("FAIL reset_firstWord got sel %0d out %h exp sel 0 out 5000", bus.select, bus.out);
        end
    endtask

    task automatic test_single();
        resetDut();
        srcData[2] = 16'h1234;
        srcValid = 8'b0000_0100; rdy = 1'b1;
        tick();
        checks++;
        if (obsInReady !== 8'b0000_0100) begin
            errors++; $display("FAIL single_inReady got %b exp 00000100", obsInReady);
        end
        checks++;
        if (bus.outValid !== 1'b1 || bus.out !== 16'h1234 || bus.select !== 3'd2) begin
            errors++; $display("FAIL single_word got v %b out %h sel %0d exp v 1 out 1234 sel 2",
                               bus.outValid, bus.out, bus.select);
        end
        tick();
        checks++;
        if (bus.outValid !== 1'b0) begin
            errors++; $display("FAIL single_drain outValid got %b exp 0", bus.outValid);
        end
    endtask

    task automatic test_all_valid();
        resetDut();
        for (int i = 0; i < 8; i++) srcData[i] = 16'hA000 + 16'(i);
        rdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            srcValid = 8'hFF;
            tick();
            checks++;
            if (obsInReady !== (8'd1 << (c % 8))) begin
                errors++; $display("FAIL all_inReady cyc %0d got %h exp %h", c, obsInReady, 8'd1 << (c % 8));
            end
            checks++;
            if (bus.outValid !== 1'b1 || bus.select !== 3'(c % 8) || bus.out !== 16'hA000 + 16'(c % 8)) begin
                errors++; $display("FAIL all_word cyc %0d got v %b sel %0d out %h exp sel %0d out %h",
                                   c, bus.outValid, bus.select, bus.out, c % 8, 16'hA000 + 16'(c % 8));
            end
        end
    endtask

    task automatic test_backpressure();
        resetDut();
        for (int i = 0; i < 8; i++) srcData[i] = 16'h3000 + 16'(i * 16'h111);
        srcValid = 8'h08; rdy = 1'b1;
        tick();
        srcValid = 8'hFF; rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obsInReady !== 8'd0) begin
                errors++; $display("FAIL bp_inReady cyc %0d got %h exp 00", c, obsInReady);
            end
            checks++;
            if (bus.outValid !== 1'b1 || bus.select !== 3'd3 || bus.out !== 16'h3333) begin
                errors++; $display("FAIL bp_hold cyc %0d got v %b sel %0d out %h exp v 1 sel 3 out 3333",
                                   c, bus.outValid, bus.select, bus.out);
            end
        end
        rdy = 1'b1;
        tick();
        checks++;
        if (obsInReady !== 8'h10) begin
            errors++; $display("FAIL bp_release inReady got %h exp 10", obsInReady);
        end
        checks++;
        if (bus.select !== 3'd4 || bus.out !== 16'h3444) begin
            errors++; $display("FAIL bp_release word got sel %0d out %h exp sel 4 out 3444", bus.select, bus.out);
        end
    endtask

    task automatic test_wrap_and_refill();
        logic [2:0] prevSel;
        logic [2:0] expSel;
        resetDut();
        for (int i = 0; i < 8; i++) srcData[i] = 16'hC000 + 16'(i);
        srcValid = 8'h40; rdy = 1'b1;
        tick();
        prevSel = 3'd6;
        for (int c = 0; c < 4; c++) begin
            srcValid = 8'h81;
            expSel = (c % 2 == 0) ? 3'd7 : 3'd0;
            tick();
            checks++;
            if (bus.select !== expSel || bus.select === prevSel || bus.out !== 16'hC000 + 16'(expSel)) begin
                errors++; $display("FAIL wrap cyc %0d got sel %0d out %h exp sel %0d", c, bus.select, bus.out, expSel);
            end
            prevSel = bus.select;
        end
        srcValid = 8'h20; rdy = 1'b1;
        tick();
        checks++;
        if (obsInReady !== 8'h20) begin
            errors++; $display("FAIL refill_inReady got %h exp 20", obsInReady);
        end
        checks++;
        if (bus.outValid !== 1'b1 || bus.select !== 3'd5 || bus.out !== 16'hC005) begin
            errors++; $display("FAIL refill_word got v %b sel %0d out %h exp v 1 sel 5 out c005",
                               bus.outValid, bus.select, bus.out);
        end
        srcValid = 8'h00;
        tick();
        checks++;
        if (bus.outValid !== 1'b0 || accepted !== emitted) begin
            errors++; $display("FAIL refill_count got v %b acc %0d emit %0d exp v 0 acc==emit",
                               bus.outValid, accepted, emitted);
        end
    endtask

    task automatic test_random();
        resetDut();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (!srcValid[i] && $urandom_range(0, 2) == 0) begin
                    srcValid[i] = 1'b1;
                    srcData[i] = 16'($urandom);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (obsInReady !== expInReady) begin
                errors++; $display("FAIL rand_inReady cyc %0d got %h exp %h", c, obsInReady, expInReady);
            end
            checks++;
            if (bus.outValid !== mFull || (mFull && (bus.out !== mOut || bus.select !== mSel))) begin
                errors++; $display("FAIL rand_word cyc %0d got v %b sel %0d out %h exp v %b sel %0d out %h",
                                   c, bus.outValid, bus.select, bus.out, mFull, mSel, mOut);
            end
        end
        checks++;
        if (accepted !== emitted + (mFull ? 1 : 0)) begin
            errors++; $display("FAIL rand_count acc %0d emit %0d held %0d", accepted, emitted, mFull);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        srcValid = 8'd0;
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) srcData[i] = 16'd0;
        bus.inA = 16'd0; bus.inB = 16'd0; bus.inC = 16'd0; bus.inD = 16'd0;
        bus.inE = 16'd0; bus.inF = 16'd0; bus.inG = 16'd0; bus.inH = 16'd0;
        bus.inValid = 8'd0;
        bus.outReady = 1'b0;
        #12;
        test_reset();
        test_single();
        test_all_valid();
        test_backpressure();
        test_wrap_and_refill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
